seven_seg_reader: RTL

SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

---
 rtl/seven_seg_reader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_reader.sv
// Samples a multiplexed seven-segment display bus and reassembles the scanned digits into a
// decoded frame, publishing it atomically once every digit has been captured in order.
module seven_seg_reader #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_en,
   output logic [4*DIGITS-1:0]   value,
   output logic                  valid,
   output logic [DIGITS-1:0]     digit_err,
   output logic [DIGITS-1:0]     blank,
   output logic                  frame_err
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [IdxW-1:0]   LastIdx = IdxW'(DIGITS - 1);
   localparam logic [CntW-1:0]   CntMax  = CntW'(STABLE_CYCLES - 1);
   localparam logic [DIGITS-1:0] One     = DIGITS'(1);

   typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

   state_e                state_q, state_d;
   logic [6:0]            seg_q, seg_p_q;
   logic [DIGITS-1:0]     den_q, den_p_q;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d, idx_nx;
   logic                  seen_q, seen_d;
   logic [4*DIGITS-1:0]   sh_val_q, sh_val_d, value_q, value_d;
   logic [DIGITS-1:0]     sh_err_q, sh_err_d, sh_blk_q, sh_blk_d;
   logic [DIGITS-1:0]     derr_q, derr_d, blk_q, blk_d;
   logic                  valid_q, ferr_q;
   logic [DIGITS-1:0]     exp_mask, nxt_mask;
   logic [3:0]            dec_nib;
   logic                  dec_err, dec_blank;
   logic                  capture, publish, abandon;

   always_comb begin
      dec_nib   = 4'h0;
      dec_err   = 1'b0;
      dec_blank = 1'b0;
      case (seg_q)
         7'h3F: dec_nib = 4'h0;
         7'h06: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h4F: dec_nib = 4'h3;
         7'h66: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h7D: dec_nib = 4'h6;
         7'h07: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h67: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h7C: dec_nib = 4'hB;
         7'h39: dec_nib = 4'hC;
         7'h5E: dec_nib = 4'hD;
         7'h79: dec_nib = 4'hE;
         7'h71: dec_nib = 4'hF;
         7'h00: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   // cnt_d is the run length of the sample just registered, so capture lines up with its edge
   always_comb begin
      cnt_d = cnt_q;
      if ((seg_q != seg_p_q) || (den_q != den_p_q)) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   assign idx_nx   = idx_q + IdxW'(1);
   assign exp_mask = One << idx_q;
   assign nxt_mask = One << idx_nx;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seen_d  = seen_q;
      capture = 1'b0;
      publish = 1'b0;
      abandon = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (den_q == One) begin
               state_d = StSettle;
               idx_d   = '0;
               seen_d  = 1'b1;
            end
         end
         StSettle: begin
            // seen_q separates a blanking gap before the strobe from the strobe dropping early
            if (den_q == '0) begin
               abandon = seen_q;
            end else if (den_q != exp_mask) begin
               abandon = 1'b1;
            end else begin
               seen_d = 1'b1;
               if (cnt_d == CntMax) begin
                  capture = 1'b1;
                  if (idx_q == LastIdx) begin
                     publish = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StHold;
                  end
               end
            end
         end
         StHold: begin
            if (den_q == exp_mask) begin
               state_d = StHold;
            end else if (den_q == '0) begin
               state_d = StSettle;
               idx_d   = idx_nx;
               seen_d  = 1'b0;
            end else if (den_q == nxt_mask) begin
               state_d = StSettle;
               idx_d   = idx_nx;
               seen_d  = 1'b1;
            end else begin
               abandon = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (abandon) begin
         state_d = StIdle;
         seen_d  = 1'b0;
      end
   end

   always_comb begin
      sh_val_d = sh_val_q;
      sh_err_d = sh_err_q;
      sh_blk_d = sh_blk_q;
      if (capture) begin
         sh_val_d[{idx_q, 2'b00} +: 4] = dec_nib;
         sh_err_d[idx_q]               = dec_err;
         sh_blk_d[idx_q]               = dec_blank;
      end
      value_d = value_q;
      derr_d  = derr_q;
      blk_d   = blk_q;
      if (publish) begin
         value_d = sh_val_d;
         derr_d  = sh_err_d;
         blk_d   = sh_blk_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         seg_q    <= '0;
         seg_p_q  <= '0;
         den_q    <= '0;
         den_p_q  <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         seen_q   <= 1'b0;
         sh_val_q <= '0;
         sh_err_q <= '0;
         sh_blk_q <= '0;
         value_q  <= '0;
         derr_q   <= '0;
         blk_q    <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seg_q    <= seg_in;
         seg_p_q  <= seg_q;
         den_q    <= dig_en;
         den_p_q  <= den_q;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         seen_q   <= seen_d;
         sh_val_q <= sh_val_d;
         sh_err_q <= sh_err_d;
         sh_blk_q <= sh_blk_d;
         value_q  <= value_d;
         derr_q   <= derr_d;
         blk_q    <= blk_d;
         valid_q  <= publish;
         ferr_q   <= abandon;
      end
   end

   assign value     = value_q;
   assign valid     = valid_q;
   assign digit_err = derr_q;
   assign blank     = blk_q;
   assign frame_err = ferr_q;

endmodule
